fd_prog_div: RTL and testbench

- Runtime-programmable integer clock divider; next generation of the fixed divide-by-2 toggle divider.
- Generates a divided clock `oclk` (period D input cycles) and a one-cycle `otick` pulse per output period.
- Divide ratio D is loaded through a valid/ready handshake and applied glitch-free at the period boundary.
- Sits beside the top-level clock tree, feeding slow-strobe consumers (display scan, debounce, UART baud).

---
 rtl/fd_pkg.sv | 24 ++
 rtl/fd_div_shadow.sv | 51 +++++
 rtl/fd_prog_div.sv | 132 +++++++++++++
 tb/tb_fd_prog_div.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared definitions for the programmable clock divider: widths, the minimum
// legal divide ratio, the stop-control state encoding and ratio helpers.
// The helpers work on 32-bit values, so CNT_W is limited to 31 bits.
package fd_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DIV_MIN   = 2;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_STOPPING = 1'b1
    } stop_state_e;

    // Ratios below 2 cannot produce a two-phase output; promote them to 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction

    // ceil(d/2) evaluated with one guard bit so d at full scale cannot wrap.
    function automatic logic [31:0] half_of(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/fd_div_shadow.sv
// Shadow register for the requested divide ratio with a valid/ready load
// handshake. One value is held at a time; the counter pops it on a wrap.
module fd_div_shadow
    import fd_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             pop_i,
    output logic             ready_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] div_next_o
);

    logic             pending_q, pending_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             accept;

    // A load is only taken while the shadow is empty; later loads are dropped.
    assign accept = load_i && !pending_q;

    // Capture a clamped ratio on accept, release the slot when it is consumed.
    always_comb begin
        pending_d = pending_q;
        shadow_d  = shadow_q;
        if (accept) begin
            pending_d = 1'b1;
            shadow_d  = CNT_W'(clamp_div(32'(div_i)));
        end else if (pop_i) begin
            pending_d = 1'b0;
        end
    end

    // Only the occupancy flag needs reset; the stored ratio is ignored while empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
        shadow_q <= shadow_d;
    end

    assign ready_o    = !pending_q;
    assign pending_o  = pending_q;
    assign div_next_o = shadow_q;

endmodule

// File: rtl/fd_prog_div.sv
// Runtime-programmable integer clock divider. Produces a registered divided
// clock (period D, high for floor(D/2) cycles, low for ceil(D/2)) and a
// one-cycle tick on each rising edge. New ratios take effect only at a wrap.
// Optional build macro FDIV_CLEAN_STOP_EN: when enable drops during the high
// phase, the divider runs on until the output falls, so it always parks low.
module fd_prog_div
    import fd_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_RST = 2
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             ienable,
    input  logic [CNT_W-1:0] idiv,
    input  logic             iload,
    output logic             oready,
    output logic             oclk,
    output logic             otick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] d_act_q, d_act_d;
    logic             oclk_q, oclk_d;
    logic             otick_q, otick_d;

    logic [CNT_W-1:0] half, hi_len, div_next;
    logic             at_wrap, at_fall, run_en, pop, pending;

    fd_div_shadow #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk_i      (iclk),
        .rst_ni     (irst_n),
        .load_i     (iload),
        .div_i      (idiv),
        .pop_i      (pop),
        .ready_o    (oready),
        .pending_o  (pending),
        .div_next_o (div_next)
    );

    // The low phase is the longer half, so the output falls after hi_len counts.
    assign half    = CNT_W'(half_of(32'(d_act_q)));
    assign hi_len  = d_act_q - half;
    assign at_wrap = (cnt_q == d_act_q - ONE);
    assign at_fall = (cnt_q == hi_len - ONE);

`ifdef FDIV_CLEAN_STOP_EN
    stop_state_e state_q, state_d;

    // Keep counting through a disable that lands in the high phase until the fall.
    always_comb begin
        state_d = state_q;
        run_en  = ienable;
        case (state_q)
            ST_RUN: begin
                if (!ienable && oclk_q) begin
                    run_en = 1'b1;
                    if (!at_fall) begin
                        state_d = ST_STOPPING;
                    end
                end
            end
            ST_STOPPING: begin
                run_en = 1'b1;
                if (ienable || at_fall) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Stop-control state register.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign run_en = ienable;
`endif

    // Counter, phase and tick; a pending ratio is swapped in only at the wrap.
    always_comb begin
        cnt_d   = cnt_q;
        d_act_d = d_act_q;
        oclk_d  = oclk_q;
        otick_d = 1'b0;
        pop     = 1'b0;
        if (run_en) begin
            if (at_wrap) begin
                cnt_d   = '0;
                oclk_d  = 1'b1;
                otick_d = 1'b1;
                pop     = 1'b1;
                if (pending) begin
                    d_act_d = div_next;
                end
            end else begin
                cnt_d = cnt_q + ONE;
                if (at_fall) begin
                    oclk_d = 1'b0;
                end
            end
        end
    end

    // Divider state registers; reset aborts the current period.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            cnt_q   <= '0;
            d_act_q <= CNT_W'(DIV_RST);
            oclk_q  <= 1'b0;
            otick_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            d_act_q <= d_act_d;
            oclk_q  <= oclk_d;
            otick_q <= otick_d;
        end
    end

    assign oclk  = oclk_q;
    assign otick = otick_q;

endmodule

// File: tb/tb_fd_prog_div.sv
// Directed bench for fd_prog_div (default CNT_W=16, DIV_RST=2). Each vector
// string lists the expected oclk/otick/oready after consecutive clock edges.
module tb_fd_prog_div;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        ienable;
    logic        iload;
    logic [15:0] idiv;
    logic        oready;
    logic        oclk;
    logic        otick;

    int checks   = 0;
    int failures = 0;

    fd_prog_div dut (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .ienable (ienable),
        .idiv    (idiv),
        .iload   (iload),
        .oready  (oready),
        .oclk    (oclk),
        .otick   (otick)
    );

    always #5 iclk = ~iclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bit_of(input string s, input int i);
        return (s.getc(i) == 8'h31) ? 32'd1 : 32'd0;
    endfunction

    // Advance one edge per character and compare all three outputs just after it.
    task automatic step_exp(input string tag, input string c, input string t, input string r);
        for (int i = 0; i < c.len(); i++) begin
            @(posedge iclk);
            #1;
            check_eq($sformatf("%s.oclk[%0d]", tag, i),   {31'd0, oclk},   bit_of(c, i));
            check_eq($sformatf("%s.otick[%0d]", tag, i),  {31'd0, otick},  bit_of(t, i));
            check_eq($sformatf("%s.oready[%0d]", tag, i), {31'd0, oready}, bit_of(r, i));
        end
    endtask

    initial begin
        irst_n  = 1'b0;
        ienable = 1'b1;
        iload   = 1'b0;
        idiv    = 16'd0;
        repeat (2) @(posedge iclk);
        #1;
        check_eq("rst.oclk",   {31'd0, oclk},   32'd0);
        check_eq("rst.otick",  {31'd0, otick},  32'd0);
        check_eq("rst.oready", {31'd0, oready}, 32'd1);
        irst_n = 1'b1;

        // Reset ratio 2: legacy toggle behaviour.
        step_exp("div2", "010101", "010101", "111111");

        // Load 5: accepted now, applied at the next wrap, then 2 high / 3 low.
        iload = 1'b1;
        idiv  = 16'd5;
        step_exp("ld5a", "0", "0", "0");
        iload = 1'b0;
        step_exp("ld5b", "11000110001", "10000100001", "11111111111");

        // Load 0 (clamped to 2), then a load of 9 while busy is dropped.
        iload = 1'b1;
        idiv  = 16'd0;
        step_exp("clampA", "1", "0", "0");
        idiv  = 16'd9;
        step_exp("ignB", "0", "0", "0");
        iload = 1'b0;
        step_exp("clampC", "0010101", "0010101", "0011111");

        // Move to D=4, then load 7 on the wrap edge: one more 4-period, then 7.
        iload = 1'b1;
        idiv  = 16'd4;
        step_exp("ld4a", "0", "0", "0");
        iload = 1'b0;
        step_exp("ld4b", "1100", "1000", "1111");
        iload = 1'b1;
        idiv  = 16'd7;
        step_exp("wrapld", "1", "1", "0");
        iload = 1'b0;
        step_exp("ld7", "10011100001", "00010000001", "00011111111");

        // D=8, then drop enable for 6 cycles one cycle into the high phase.
        iload = 1'b1;
        idiv  = 16'd8;
        step_exp("ld8a", "1", "0", "0");
        iload = 1'b0;
        step_exp("ld8b", "100001", "000001", "000001");
        step_exp("ld8c", "1", "0", "1");
        ienable = 1'b0;
`ifdef FDIV_CLEAN_STOP_EN
        step_exp("stop", "110000", "000000", "111111");
        ienable = 1'b1;
        step_exp("resume", "0001111", "0001000", "1111111");
`else
        step_exp("stop", "111111", "000000", "111111");
        ienable = 1'b1;
        step_exp("resume", "1100001", "0000001", "1111111");
`endif

        // Reset while a load of 9 is pending: everything returns to reset values.
        iload = 1'b1;
        idiv  = 16'd9;
        @(posedge iclk);
        #1;
        check_eq("ld9.oready", {31'd0, oready}, 32'd0);
        iload  = 1'b0;
        irst_n = 1'b0;
        @(posedge iclk);
        #1;
        check_eq("rst2.oclk",   {31'd0, oclk},   32'd0);
        check_eq("rst2.otick",  {31'd0, otick},  32'd0);
        check_eq("rst2.oready", {31'd0, oready}, 32'd1);
        irst_n = 1'b1;
        step_exp("postrst", "0101", "0101", "1111");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
